// File: rtl/pattern_pkg.sv
// Shared definitions for the pattern sequencer: the mode encoding, the noise
// LFSR step and the colour-bar index comparator chain.
package pattern_pkg;

  typedef enum logic [1:0] {
    MODE_GRAD  = 2'd0,
    MODE_NOISE = 2'd1,
    MODE_BARS  = 2'd2,
    MODE_SOLID = 2'd3
  } mode_e;

  localparam int BAR_COUNT = 8;

  // One step of the 8-bit noise generator (shift left, feedback from bits 7 and 6).
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[6]};
  endfunction

  // Highest bar whose left edge is at or left of x; built as a comparator
  // chain so no divider is needed. Anything beyond the last edge stays in bar 7.
  function automatic logic [2:0] bar_index(input logic [9:0] x, input logic [9:0] bar_w);
    logic [2:0]  idx;
    logic [13:0] thr;
    idx = 3'd0;
    for (int i = 1; i < BAR_COUNT; i++) begin
      thr = 14'(i) * {4'd0, bar_w};
      if ({4'd0, x} >= thr) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pattern_sequencer_if.sv
// Configuration handshake between a mode requester and the pattern sequencer.
interface pattern_sequencer_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic        cfg_auto;
  logic [23:0] cfg_color;

  modport master (output cfg_valid, output cfg_mode, output cfg_auto, output cfg_color,
                  input  cfg_ready);
  modport slave  (input  cfg_valid, input  cfg_mode, input  cfg_auto, input  cfg_color,
                  output cfg_ready);
endinterface

// File: rtl/pattern_lfsr8.sv
// Reusable 8-bit noise LFSR. value_o is the value in effect this cycle: the
// seed when reloading, otherwise the stored state. When enabled the state
// steps from that value, so a reload cycle emits the seed and steps past it.
module pattern_lfsr8
  import pattern_pkg::*;
#(
  parameter logic [7:0] RST_SEED = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       reload_i,
  input  logic [7:0] seed_i,
  output logic [7:0] value_o
);

  logic [7:0] state_q;
  logic [7:0] state_d;
  logic [7:0] cur_s;

  // Select current value and compute the next state.
  always_comb begin
    cur_s = reload_i ? seed_i : state_q;
    if (en_i) begin
      state_d = lfsr8_next(cur_s);
    end else begin
      state_d = cur_s;
    end
  end

  // State register, seeded on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RST_SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign value_o = cur_s;

endmodule

// File: rtl/pattern_sequencer.sv
// Frame-synchronous pattern source for the vga pixel path. Picks gradient,
// noise, colour bars or a solid colour and only switches at frame starts.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int         H_ACTIVE        = 640,
  parameter int         FRAMES_PER_MODE = 60,
  parameter bit         AUTO_DEFAULT    = 1'b1,
  parameter logic [7:0] LFSR_SEED       = 8'h01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  pattern_sequencer_if.slave    cfg,
  output logic [7:0]            r,
  output logic [7:0]            g,
  output logic [7:0]            b,
  output logic [1:0]            mode,
  output logic                  frame_start
);

  localparam int                CNT_W    = $clog2(FRAMES_PER_MODE) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAMES_PER_MODE - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [9:0]        BAR_W    = 10'(H_ACTIVE / BAR_COUNT);

  logic             prev_zero_q, frame_start_q, cfg_ready_q, cfg_ready_d;
  mode_e            mode_q, mode_d, pend_mode_q, pend_mode_d;
  logic             auto_q, auto_d, pend_auto_q, pend_auto_d;
  logic [23:0]      color_q, color_d, pend_color_q, pend_color_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       r_q, g_q, b_q, r_d, g_d, b_d;
  logic             at_zero_s, fs_s, xfer_s, lfsr_en_s, lfsr_reload_s;
  logic [7:0]       noise_s;
  logic [2:0]       bar_s;

  // Frame start detection, handshake capture and frame-boundary scheduling.
  always_comb begin
    at_zero_s    = (x == 10'd0) && (y == 10'd0);
    fs_s         = at_zero_s && !prev_zero_q;
    xfer_s       = cfg.cfg_valid && cfg_ready_q;
    mode_d       = mode_q;
    auto_d       = auto_q;
    color_d      = color_q;
    cnt_d        = cnt_q;
    cfg_ready_d  = cfg_ready_q;
    pend_mode_d  = pend_mode_q;
    pend_auto_d  = pend_auto_q;
    pend_color_d = pend_color_q;
    if (xfer_s) begin
      cfg_ready_d  = 1'b0;
      pend_mode_d  = mode_e'(cfg.cfg_mode);
      pend_auto_d  = cfg.cfg_auto;
      pend_color_d = cfg.cfg_color;
    end else begin
      cfg_ready_d  = cfg_ready_q;
    end
    // A slot that was already pending at this frame start beats auto-advance;
    // a request captured on this very cycle waits for the next frame.
    if (fs_s) begin
      if (!cfg_ready_q) begin
        mode_d      = pend_mode_q;
        auto_d      = pend_auto_q;
        color_d     = pend_color_q;
        cnt_d       = '0;
        cfg_ready_d = 1'b1;
      end else if (auto_q && (cnt_q == CNT_LAST)) begin
        mode_d = mode_e'(mode_q + 2'd1);
        cnt_d  = '0;
      end else if (auto_q) begin
        cnt_d  = cnt_q + CNT_ONE;
      end else begin
        cnt_d  = cnt_q;
      end
    end else begin
      mode_d = mode_q;
    end
    lfsr_en_s     = (mode_d == MODE_NOISE);
    lfsr_reload_s = fs_s && (mode_d == MODE_NOISE) && (mode_q != MODE_NOISE);
  end

  pattern_lfsr8 #(
    .RST_SEED (LFSR_SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst      (rst),
    .en_i     (lfsr_en_s),
    .reload_i (lfsr_reload_s),
    .seed_i   (LFSR_SEED),
    .value_o  (noise_s)
  );

  // Pixel generation from the mode/colour in effect this cycle (new mode on a frame start).
  always_comb begin
    bar_s = bar_index(x, BAR_W);
    case (mode_d)
      MODE_GRAD: begin
        r_d = x[7:0];
        g_d = y[9:2];
        b_d = 8'h00;
      end
      MODE_NOISE: begin
        r_d = noise_s;
        g_d = noise_s;
        b_d = noise_s;
      end
      MODE_BARS: begin
        r_d = {8{bar_s[2]}};
        g_d = {8{bar_s[1]}};
        b_d = {8{bar_s[0]}};
      end
      MODE_SOLID: begin
        r_d = color_d[23:16];
        g_d = color_d[15:8];
        b_d = color_d[7:0];
      end
      default: begin
        r_d = 8'h00;
        g_d = 8'h00;
        b_d = 8'h00;
      end
    endcase
  end

  // Control state, pending slot and registered pixel outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_zero_q   <= 1'b0;
      frame_start_q <= 1'b0;
      cfg_ready_q   <= 1'b1;
      mode_q        <= MODE_GRAD;
      auto_q        <= AUTO_DEFAULT;
      color_q       <= 24'h000000;
      cnt_q         <= '0;
      pend_mode_q   <= MODE_GRAD;
      pend_auto_q   <= 1'b0;
      pend_color_q  <= 24'h000000;
      r_q           <= 8'h00;
      g_q           <= 8'h00;
      b_q           <= 8'h00;
    end else begin
      prev_zero_q   <= at_zero_s;
      frame_start_q <= fs_s;
      cfg_ready_q   <= cfg_ready_d;
      mode_q        <= mode_d;
      auto_q        <= auto_d;
      color_q       <= color_d;
      cnt_q         <= cnt_d;
      pend_mode_q   <= pend_mode_d;
      pend_auto_q   <= pend_auto_d;
      pend_color_q  <= pend_color_d;
      r_q           <= r_d;
      g_q           <= g_d;
      b_q           <= b_d;
    end
  end

  assign cfg.cfg_ready = cfg_ready_q;
  assign r             = r_q;
  assign g             = g_q;
  assign b             = b_q;
  assign mode          = mode_q;
  assign frame_start   = frame_start_q;

endmodule

// File: tb/tb_pattern_sequencer.sv
// Directed bench for pattern_sequencer with FRAMES_PER_MODE=2. Expected pixels
// are queued when a pixel position is driven and compared one cycle later.
module tb_pattern_sequencer;

  logic       clk;
  logic       rst;
  logic [9:0] x;
  logic [9:0] y;
  logic [7:0] r, g, b;
  logic [1:0] mode;
  logic       frame_start;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    logic [23:0] exp;
  } px_exp_t;

  px_exp_t sb[$];

  pattern_sequencer_if cfg_if();

  pattern_sequencer #(
    .H_ACTIVE        (640),
    .FRAMES_PER_MODE (2),
    .AUTO_DEFAULT    (1'b1),
    .LFSR_SEED       (8'h01)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .x           (x),
    .y           (y),
    .cfg         (cfg_if),
    .r           (r),
    .g           (g),
    .b           (b),
    .mode        (mode),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one pixel position, let the DUT sample it, then compare the queued expectation.
  task automatic px(input logic [9:0] xi, input logic [9:0] yi, input bit chk, input logic [23:0] exp);
    px_exp_t e;
    x = xi;
    y = yi;
    sb.push_back('{chk: chk, exp: exp});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    if (e.chk) check("pixel", {r, g, b}, e.exp);
  endtask

  task automatic cfg_drive(input logic v, input logic [1:0] m, input logic a, input logic [23:0] c);
    cfg_if.cfg_valid = v;
    cfg_if.cfg_mode  = m;
    cfg_if.cfg_auto  = a;
    cfg_if.cfg_color = c;
  endtask

  logic [1:0] exp_mode [0:10];
  logic [1:0] prev_mode;
  bit         entering_noise;
  bit         is_bars;

  initial begin
    exp_mode = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0, 2'd0, 2'd1, 2'd1};
    rst = 1'b0;
    x   = 10'd5;
    y   = 10'd5;
    cfg_drive(1'b0, 2'd0, 1'b0, 24'h000000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_rgb", {r, g, b}, 24'h000000);
    check("reset_mode", {22'd0, mode}, 24'd0);
    check("reset_ready", {23'd0, cfg_if.cfg_ready}, 24'd1);
    check("reset_fs", {23'd0, frame_start}, 24'd0);
    @(negedge clk);
    rst = 1'b1;

    // Gradient before any frame start.
    px(10'h1A5, 10'h0F3, 1'b1, 24'hA53C00);
    check("grad_mode", {22'd0, mode}, 24'd0);

    // Auto-cycle across eleven frames, with noise and bar checks along the way.
    for (int k = 0; k < 11; k++) begin
      prev_mode      = (k == 0) ? 2'd0 : exp_mode[k-1];
      entering_noise = (exp_mode[k] == 2'd1) && (prev_mode != 2'd1);
      is_bars        = (exp_mode[k] == 2'd2);
      px(10'd0, 10'd0, entering_noise || is_bars, entering_noise ? 24'h010101 : 24'h000000);
      check("fs_pulse", {23'd0, frame_start}, 24'd1);
      check("auto_mode", {22'd0, mode}, {22'd0, exp_mode[k]});
      px(10'd0, 10'd0, entering_noise || is_bars, entering_noise ? 24'h020202 : 24'h000000);
      check("fs_single", {23'd0, frame_start}, 24'd0);
      if (entering_noise) begin
        px(10'd1, 10'd0, 1'b1, 24'h040404);
      end else if (is_bars) begin
        px(10'd79,  10'd0, 1'b1, 24'h000000);
        px(10'd80,  10'd0, 1'b1, 24'h0000FF);
        px(10'd639, 10'd0, 1'b1, 24'hFFFFFF);
        px(10'd700, 10'd0, 1'b1, 24'hFFFFFF);
      end else begin
        px(10'd1, 10'd0, 1'b0, 24'h000000);
      end
      px(10'd2, 10'd1, 1'b0, 24'h000000);
    end

    // Mid-frame config: solid 0x123456, auto off; wins over the pending auto wrap.
    cfg_drive(1'b1, 2'd3, 1'b0, 24'h123456);
    px(10'd5, 10'd5, 1'b0, 24'h000000);
    cfg_drive(1'b0, 2'd0, 1'b0, 24'h000000);
    check("cfg_ready_low", {23'd0, cfg_if.cfg_ready}, 24'd0);
    px(10'd6, 10'd5, 1'b0, 24'h000000);
    check("cfg_ready_hold", {23'd0, cfg_if.cfg_ready}, 24'd0);
    check("mode_midframe", {22'd0, mode}, 24'd1);
    px(10'd0, 10'd0, 1'b1, 24'h123456);
    check("solid_mode", {22'd0, mode}, 24'd3);
    check("cfg_ready_back", {23'd0, cfg_if.cfg_ready}, 24'd1);
    for (int j = 0; j < 5; j++) begin
      px(10'd0, 10'd0, 1'b1, 24'h123456);
      check("solid_stays", {22'd0, mode}, 24'd3);
      px(10'd3, 10'd3, 1'b1, 24'h123456);
    end

    // Request accepted on the frame-start cycle while auto is at wrap.
    cfg_drive(1'b1, 2'd0, 1'b1, 24'h000000);
    px(10'd4, 10'd4, 1'b0, 24'h000000);
    cfg_drive(1'b0, 2'd0, 1'b0, 24'h000000);
    px(10'd0, 10'd0, 1'b1, 24'h000000);
    check("sim_grad_mode", {22'd0, mode}, 24'd0);
    px(10'd1, 10'd1, 1'b0, 24'h000000);
    px(10'd0, 10'd0, 1'b1, 24'h000000);
    check("sim_cnt1_mode", {22'd0, mode}, 24'd0);
    px(10'd1, 10'd1, 1'b0, 24'h000000);
    cfg_drive(1'b1, 2'd2, 1'b1, 24'hC0FFEE);
    px(10'd0, 10'd0, 1'b1, 24'h010101);
    cfg_drive(1'b0, 2'd0, 1'b0, 24'h000000);
    check("sim_auto_adv", {22'd0, mode}, 24'd1);
    check("sim_ready_low", {23'd0, cfg_if.cfg_ready}, 24'd0);
    px(10'd1, 10'd1, 1'b1, 24'h020202);
    px(10'd0, 10'd0, 1'b1, 24'h000000);
    check("sim_applied", {22'd0, mode}, 24'd2);
    check("sim_ready_back", {23'd0, cfg_if.cfg_ready}, 24'd1);
    px(10'd1, 10'd1, 1'b0, 24'h000000);
    px(10'd0, 10'd0, 1'b1, 24'h000000);
    check("sim_cnt_reset", {22'd0, mode}, 24'd2);
    px(10'd1, 10'd1, 1'b0, 24'h000000);
    px(10'd0, 10'd0, 1'b1, 24'hC0FFEE);
    check("sim_wrap", {22'd0, mode}, 24'd3);

    // Reset in the middle of a line with a request pending.
    px(10'd300, 10'd10, 1'b1, 24'hC0FFEE);
    cfg_drive(1'b1, 2'd3, 1'b0, 24'hFFFFFF);
    px(10'd301, 10'd10, 1'b0, 24'h000000);
    cfg_drive(1'b0, 2'd0, 1'b0, 24'h000000);
    check("pend_ready_low", {23'd0, cfg_if.cfg_ready}, 24'd0);
    #3;
    rst = 1'b0;
    #1;
    check("rst_mid_rgb", {r, g, b}, 24'h000000);
    check("rst_mid_mode", {22'd0, mode}, 24'd0);
    check("rst_mid_ready", {23'd0, cfg_if.cfg_ready}, 24'd1);
    @(negedge clk);
    rst = 1'b1;
    px(10'd0, 10'd0, 1'b1, 24'h000000);
    check("post_rst_fs", {23'd0, frame_start}, 24'd1);
    check("post_rst_mode", {22'd0, mode}, 24'd0);
    px(10'h1A5, 10'h0F3, 1'b1, 24'hA53C00);
    px(10'd0, 10'd0, 1'b1, 24'h010101);
    check("pend_discarded", {22'd0, mode}, 24'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
